// File: rtl/strip_mine_ctrl.sv
// Strip-mining controller: splits a vector request of avl elements into strips of at most
// vlmax = (VLEN/sew)*lmul elements and issues them one at a time over a valid/ready handshake.
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   CALC  | compute vlmax, validate sew/lmul
//   ISSUE | present current strip, advance on handshake
//   DONE  | one-cycle done pulse
//   ERR   | one-cycle err pulse for illegal sew/lmul
module strip_mine_ctrl #(
    parameter int VLEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_sew,
    input  logic [4:0] req_lmul,
    input  logic [8:0] req_avl,
    output logic       strip_valid,
    input  logic       strip_ready,
    output logic [8:0] strip_vl,
    output logic [8:0] strip_base,
    output logic [8:0] strip_idx,
    output logic       strip_last,
    input  logic       abort,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_DONE, S_ERR} state_t;

    state_t     state_q;
    logic [6:0] sew_q;
    logic [4:0] lmul_q;
    logic [8:0] avl_q;
    logic [8:0] vlmax_q;
    logic [8:0] rem_q;
    logic [8:0] base_q;
    logic [8:0] idx_q;
    logic [8:0] strip_vl_q;
    logic       req_ready_q;
    logic       strip_valid_q;
    logic       strip_last_q;
    logic       done_q;
    logic       err_q;

    logic       sew_ok;
    logic       lmul_ok;
    logic [2:0] sew_sh;
    logic [2:0] lmul_sh;
    logic [8:0] vlmax_d;
    logic [8:0] rem_d;

    function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
        return (a < b) ? a : b;
    endfunction

    // sew and lmul are powers of two, so the divide and multiply reduce to shifts
    always_comb begin
        sew_ok  = 1'b1;
        lmul_ok = 1'b1;
        sew_sh  = 3'd0;
        lmul_sh = 3'd0;
        case (sew_q)
            7'd4:    sew_sh = 3'd2;
            7'd8:    sew_sh = 3'd3;
            7'd16:   sew_sh = 3'd4;
            7'd32:   sew_sh = 3'd5;
            7'd64:   sew_sh = 3'd6;
            default: sew_ok = 1'b0;
        endcase
        case (lmul_q)
            5'd1:    lmul_sh = 3'd0;
            5'd2:    lmul_sh = 3'd1;
            5'd4:    lmul_sh = 3'd2;
            5'd8:    lmul_sh = 3'd3;
            5'd16:   lmul_sh = 3'd4;
            default: lmul_ok = 1'b0;
        endcase
        vlmax_d = 9'((VLEN >> sew_sh) << lmul_sh);
        rem_d   = rem_q - strip_vl_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sew_q         <= '0;
            lmul_q        <= '0;
            avl_q         <= '0;
            vlmax_q       <= '0;
            rem_q         <= '0;
            base_q        <= '0;
            idx_q         <= '0;
            strip_vl_q    <= '0;
            req_ready_q   <= 1'b1;
            strip_valid_q <= 1'b0;
            strip_last_q  <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        sew_q       <= req_sew;
                        lmul_q      <= req_lmul;
                        avl_q       <= req_avl;
                        req_ready_q <= 1'b0;
                        state_q     <= S_CALC;
                    end
                end
                S_CALC: begin
                    vlmax_q <= vlmax_d;
                    rem_q   <= avl_q;
                    base_q  <= '0;
                    idx_q   <= '0;
                    if (abort) begin
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (!(sew_ok && lmul_ok)) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else if (avl_q == 9'd0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        strip_valid_q <= 1'b1;
                        strip_vl_q    <= min9(vlmax_d, avl_q);
                        strip_last_q  <= (avl_q <= vlmax_d);
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // abort wins even when it coincides with a handshake
                    if (abort) begin
                        strip_valid_q <= 1'b0;
                        strip_last_q  <= 1'b0;
                        req_ready_q   <= 1'b1;
                        state_q       <= S_IDLE;
                    end else if (strip_ready) begin
                        rem_q  <= rem_d;
                        base_q <= base_q + strip_vl_q;
                        idx_q  <= idx_q + 9'd1;
                        if (strip_last_q) begin
                            strip_valid_q <= 1'b0;
                            strip_last_q  <= 1'b0;
                            done_q        <= 1'b1;
                            state_q       <= S_DONE;
                        end else begin
                            strip_vl_q   <= min9(vlmax_q, rem_d);
                            strip_last_q <= (rem_d <= vlmax_q);
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign strip_valid = strip_valid_q;
    assign strip_vl    = strip_vl_q;
    assign strip_base  = base_q;
    assign strip_idx   = idx_q;
    assign strip_last  = strip_last_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: doc/strip_mine_ctrl.md
STRIP_MINE_CTRL -- requirements
Module: strip_mine_ctrl

Interface
REQ-001 Parameter: VLEN, default 64, vector register length in bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  new vector-operation request present.
REQ-005 req_ready  out  1  block can accept a request; high only in IDLE.
REQ-006 req_sew  in  7  element width in bits; legal values 4, 8, 16, 32, 64.
REQ-007 req_lmul  in  5  register group multiplier; legal values 1, 2, 4, 8, 16.
REQ-008 req_avl  in  9  application vector length, 0..511 elements.
REQ-009 strip_valid  out  1  strip descriptor valid.
REQ-010 strip_ready  in  1  downstream accepts strip.
REQ-011 strip_vl  out  9  element count of current strip.
REQ-012 strip_base  out  9  index of the strip's first element.
REQ-013 strip_idx  out  9  strip ordinal, starting at 0.
REQ-014 strip_last  out  1  current strip is the final one.
REQ-015 abort  in  1  synchronous cancel of the active request.
REQ-016 done  out  1  one-cycle pulse when all strips are accepted.
REQ-017 err  out  1  one-cycle pulse for an illegal SEW/LMUL request.

Function
REQ-018 States: IDLE, CALC, ISSUE, DONE, ERR.
REQ-019 Accept: req_valid && req_ready in IDLE latches sew, lmul and avl, then moves to CALC.
REQ-020 CALC, one cycle:
- registers vlmax = (VLEN / sew) * lmul as a 9-bit value (max 256);
- sets remaining = avl and base = idx = 0;
- next state is ERR if sew or lmul is illegal, else DONE if avl == 0, else ISSUE.
REQ-021 ISSUE drives strip_valid = 1 with:
- strip_vl = min(vlmax, remaining);
- strip_base = base, strip_idx = idx;
- strip_last = (remaining <= vlmax).
REQ-022 Handshake: strip_valid && strip_ready completes a strip; on the next edge remaining -= strip_vl, base += strip_vl, idx += 1.
REQ-023 Handshake on a strip with strip_last = 1 moves to DONE.
REQ-024 Stalls: while strip_valid && !strip_ready, all strip_* outputs hold stable; strip_valid never deasserts without a handshake, except on abort or reset.
REQ-025 DONE asserts done = 1 for exactly one cycle, then returns to IDLE.
REQ-026 ERR asserts err = 1 for exactly one cycle, issues no strips, then returns to IDLE.
REQ-027 Latency: first strip_valid appears 2 cycles after acceptance; req_ready returns 2 cycles after the last handshake.
REQ-028 abort = 1 in CALC or ISSUE: next state is IDLE, no done pulse, any pending strip is dropped; abort is ignored in IDLE, DONE and ERR.
REQ-029 abort coincident with a strip handshake: the handshake counts as accepted, but abort still wins and no done pulse is generated.
REQ-030 All arithmetic is unsigned 9-bit; remaining never underflows, because strip_vl <= remaining.
REQ-031 Request inputs are sampled only at acceptance; changes afterward have no effect.

Reset
REQ-032 rst_n low asynchronously forces:
- state = IDLE;
- req_ready = 1;
- strip_valid = strip_last = done = err = 0;
- strip_vl = strip_base = strip_idx = 0;
- internal vlmax, remaining and base = 0.
REQ-033 Reset asserted mid-operation discards the active request with no done or err pulse; the first post-reset cycle shows req_ready = 1.

Verification
REQ-034 Nominal: sew = 32, lmul = 2, avl = 10, strip_ready tied 1 -> three strips:
- vl = 4, 4, 2;
- base = 0, 4, 8; idx = 0, 1, 2;
- strip_last only on the third strip;
- done one cycle after the third handshake.
REQ-035 Zero length: sew = 8, lmul = 1, avl = 0 -> no strip_valid; done pulses 2 cycles after acceptance.
REQ-036 Illegal config: sew = 12, lmul = 4, avl = 100 -> err pulses 2 cycles after acceptance; done and strip_valid stay 0.
REQ-037 Backpressure: sew = 4, lmul = 16, avl = 300 -> first strip vl = 256 held stable for 3 stalled cycles; second strip vl = 44, base = 256, strip_last = 1.
REQ-038 Abort/reset: sew = 64, lmul = 1, avl = 5:
- abort after the 2nd handshake -> IDLE next cycle, no done, req_ready = 1;
- repeat with rst_n pulsed low mid-ISSUE -> all outputs at reset values immediately.
